// File: rtl/dreg_pkg.sv
// dreg_pkg: op codes shared by the register bank and its channels.
package dreg_pkg;
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_INVERT = 2'b11;
endpackage

// File: rtl/dreg_chan.sv
// dreg_chan: one clocked storage channel with true/complement outputs, loaded flag and change pulse.
module dreg_chan
    import dreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             loaded,
    output logic             changed
);
    logic [WIDTH-1:0] q_nx;
    logic             loaded_nx;
    always_comb begin
        q_nx      = op == OP_LOAD   ? d :
                    op == OP_CLEAR  ? RST_VAL :
                    op == OP_INVERT ? ~q : q;
        loaded_nx = op == OP_LOAD ? 1'b1 : op == OP_CLEAR ? 1'b0 : loaded;
    end
    // q_n is registered from the same next value so it can never lag q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= RST_VAL;
            q_n     <= ~RST_VAL;
            loaded  <= 1'b0;
            changed <= 1'b0;
        end else begin
            q       <= q_nx;
            q_n     <= ~q_nx;
            loaded  <= loaded_nx;
            changed <= q_nx != q;
        end
    end
endmodule

// File: rtl/dreg_bank.sv
// dreg_bank: CH independent clocked channels replacing level-sensitive latches; freeze forces HOLD.
module dreg_bank
    import dreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic [2*CH-1:0]     op,
    input  logic [WIDTH*CH-1:0] D,
    output logic [WIDTH*CH-1:0] Q,
    output logic [WIDTH*CH-1:0] Q_n,
    output logic [CH-1:0]       loaded,
    output logic [CH-1:0]       changed
);
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [1:0] op_c;
        assign op_c = freeze ? OP_HOLD : op[2*c +: 2];
        dreg_chan #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .op      (op_c),
            .d       (D[c*WIDTH +: WIDTH]),
            .q       (Q[c*WIDTH +: WIDTH]),
            .q_n     (Q_n[c*WIDTH +: WIDTH]),
            .loaded  (loaded[c]),
            .changed (changed[c])
        );
    end
endmodule

// File: tb/tb_dreg_bank.sv
// tb_dreg_bank: directed and random checks of dreg_bank against a behavioural model.
module tb_dreg_bank;
    localparam int W = 8;
    localparam int N = 4;
    localparam logic [1:0] H = 2'd0, L = 2'd1, C = 2'd2, I = 2'd3;

    logic clk = 1'b0, rst = 1'b1, freeze = 1'b0;
    logic [2*N-1:0] op = '0;
    logic [W*N-1:0] d = '0;
    logic [W*N-1:0] q, q_n;
    logic [N-1:0] loaded, changed;
    int checks = 0, errors = 0;

    logic [W-1:0] mq[N];
    logic [N-1:0] ml, mc;
    logic [W*N-1:0] qs;
    logic [N-1:0] ls;

    always #5 clk = ~clk;

    dreg_bank #(.WIDTH(W), .CH(N), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .op(op), .D(d),
        .Q(q), .Q_n(q_n), .loaded(loaded), .changed(changed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) mq[c] = '0;
        ml = '0;
        mc = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < N; c++) begin
            logic [W-1:0] old;
            int code;
            old = mq[c];
            code = freeze ? 0 : int'(op[2*c +: 2]);
            if (code == 1) begin mq[c] = d[c*W +: W]; ml[c] = 1'b1; end
            else if (code == 2) begin mq[c] = '0; ml[c] = 1'b0; end
            else if (code == 3) mq[c] = ~old;
            mc[c] = mq[c] != old;
        end
    endtask

    function automatic logic [W*N-1:0] mq_bus();
        logic [W*N-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = mq[c];
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".Q"}, q, mq_bus());
        chk({tag, ".Q_n"}, q_n, ~mq_bus());
        chk({tag, ".loaded"}, 32'(loaded), 32'(ml));
        chk({tag, ".changed"}, 32'(changed), 32'(mc));
    endtask

    task automatic step(input string tag, input logic [7:0] o, input logic [31:0] dd, input logic f);
        op = o;
        d = dd;
        freeze = f;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("por");
        rst = 1'b0;

        step("ld_a5", {L, L, L, L}, {4{8'hA5}}, 1'b0);
        chk("pre_rst.Q", q, 32'hA5A5A5A5);
        #3 rst = 1'b1;
        #1;
        chk("async_rst.Q", q, 32'h0);
        chk("async_rst.Q_n", q_n, 32'hFFFFFFFF);
        chk("async_rst.loaded", 32'(loaded), 32'h0);
        chk("async_rst.changed", 32'(changed), 32'h0);
        model_reset();
        #1 rst = 1'b0;

        step("ld3c", {H, H, H, L}, 32'h0000003C, 1'b0);
        chk("ld3c.q0", 32'(q[7:0]), 32'h3C);
        chk("ld3c.qn0", 32'(q_n[7:0]), 32'hC3);
        chk("ld3c.loaded0", 32'(loaded[0]), 32'h1);
        chk("ld3c.changed0", 32'(changed[0]), 32'h1);
        step("hold", {H, H, H, H}, 32'h0, 1'b0);
        chk("pulse_end.changed0", 32'(changed[0]), 32'h0);
        step("ld3c_again", {H, H, H, L}, 32'h0000003C, 1'b0);
        chk("ld_same.changed0", 32'(changed[0]), 32'h0);

        step("ld0f", {H, H, L, H}, 32'h00000F00, 1'b0);
        step("inv1", {H, H, I, H}, 32'h0, 1'b0);
        chk("inv1.q1", 32'(q[15:8]), 32'hF0);
        chk("inv1.changed1", 32'(changed[1]), 32'h1);
        step("inv2", {H, H, I, H}, 32'h0, 1'b0);
        chk("inv2.q1", 32'(q[15:8]), 32'h0F);
        chk("inv2.changed1", 32'(changed[1]), 32'h1);

        step("ld77", {H, L, H, H}, 32'h00770000, 1'b0);
        chk("ld77.loaded2", 32'(loaded[2]), 32'h1);
        step("clr1", {H, C, H, H}, 32'h0, 1'b0);
        chk("clr1.q2", 32'(q[23:16]), 32'h0);
        chk("clr1.loaded2", 32'(loaded[2]), 32'h0);
        chk("clr1.changed2", 32'(changed[2]), 32'h1);
        step("clr2", {H, C, H, H}, 32'h0, 1'b0);
        chk("clr2.changed2", 32'(changed[2]), 32'h0);

        qs = q;
        ls = loaded;
        step("frz", {L, L, L, L}, {4{8'h55}}, 1'b1);
        chk("frz.Q", q, qs);
        chk("frz.loaded", 32'(loaded), 32'(ls));
        chk("frz.changed", 32'(changed), 32'h0);
        step("unfrz", {L, L, L, L}, {4{8'h55}}, 1'b0);
        chk("unfrz.Q", q, 32'h55555555);
        chk("unfrz.loaded", 32'(loaded), 32'hF);

        step("setup6", {L, L, L, L}, 32'h44332211, 1'b0);
        step("mixed", {H, C, I, L}, 32'hEEEEEE99, 1'b0);
        chk("mixed.Q", q, 32'h4400DD99);
        chk("mixed.changed", 32'(changed), 32'h7);
        chk("mixed.loaded", 32'(loaded), 32'hB);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] rd;
            rd = $urandom;
            if ($urandom_range(0, 3) == 0) rd = q;
            step("soak", 8'($urandom), rd, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
